// File: rtl/types.sv
// Shared types and geometry constants for the instruction cache.
package types;

   typedef enum logic [1:0] {
      IDLE,
      LOOKUP,
      FILL
   } imem_cache_state_t;

   localparam int unsigned IMEM_LINE_BEATS  = 4;
   localparam int unsigned IMEM_PMEM_WIDTH  = 64;
   localparam int unsigned IMEM_LINE_BITS   = 256;
   localparam int unsigned IMEM_OFFSET_BITS = 5;
   localparam int unsigned IMEM_BEAT_BITS   = $clog2(IMEM_LINE_BEATS);

endpackage

// File: rtl/imem_cache_array.sv
// Data and tag storage: one 256-bit line plus tag per set, beat-wide synchronous
// writes and combinational reads. Contents are intentionally not reset.
module imem_cache_array
   import types::*;
#(
   parameter int unsigned NUM_SETS = 16,
   parameter int unsigned IDX_W    = $clog2(NUM_SETS),
   parameter int unsigned TAG_W    = 27 - IDX_W
) (
   input  logic                       clk,
   input  logic                       we,
   input  logic [IDX_W-1:0]           index,
   input  logic [IMEM_BEAT_BITS-1:0]  beat,
   input  logic [IMEM_PMEM_WIDTH-1:0] wdata,
   input  logic [TAG_W-1:0]           wtag,
   output logic [IMEM_LINE_BITS-1:0]  rline,
   output logic [TAG_W-1:0]           rtag
);

   logic [IMEM_LINE_BITS-1:0] data_q [NUM_SETS];
   logic [TAG_W-1:0]          tag_q  [NUM_SETS];

   always_ff @(posedge clk) begin
      if (we) begin
         data_q[index][{beat, 6'b0} +: IMEM_PMEM_WIDTH] <= wdata;
         tag_q[index]                                   <= wtag;
      end
   end

   assign rline = data_q[index];
   assign rtag  = tag_q[index];

endmodule

// File: rtl/imem_cache.sv
// Direct-mapped read-only instruction cache with 4-beat burst line fill.
// Define IMEM_CACHE_PERF_EN to add saturating hit_count / miss_count outputs.
module imem_cache
   import types::*;
#(
   parameter int unsigned NUM_SETS = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       imem_read,
   input  logic [31:0]                imem_address,
   output logic                       imem_resp,
   output logic [31:0]                imem_rdata,
   input  logic                       flush,
   output logic                       pmem_read,
   output logic [31:0]                pmem_address,
   input  logic [IMEM_PMEM_WIDTH-1:0] pmem_rdata,
   input  logic                       pmem_resp
`ifdef IMEM_CACHE_PERF_EN
   ,
   output logic [31:0]                hit_count,
   output logic [31:0]                miss_count
`endif
);

   localparam int unsigned IDX_W = $clog2(NUM_SETS);
   localparam int unsigned TAG_W = 27 - IDX_W;

   imem_cache_state_t         state_q, state_d;
   logic [31:2]               req_addr_q, req_addr_d;
   logic [NUM_SETS-1:0]       valid_q, valid_d;
   logic [IMEM_BEAT_BITS-1:0] beat_q, beat_d;
   logic                      fill_flush_q, fill_flush_d;

   logic [IDX_W-1:0]          idx;
   logic [TAG_W-1:0]          tag;
   logic [IMEM_LINE_BITS-1:0] rline;
   logic [TAG_W-1:0]          rtag;
   logic                      hit;
   logic                      we;
   logic                      unused_addr;

   assign unused_addr = ^imem_address[1:0];

   assign idx = req_addr_q[IMEM_OFFSET_BITS +: IDX_W];
   assign tag = req_addr_q[31 -: TAG_W];
   assign hit = (state_q == LOOKUP) && valid_q[idx] && (rtag == tag);
   assign we  = (state_q == FILL) && pmem_resp;

   imem_cache_array #(
      .NUM_SETS (NUM_SETS),
      .IDX_W    (IDX_W),
      .TAG_W    (TAG_W)
   ) u_array (
      .clk   (clk),
      .we    (we),
      .index (idx),
      .beat  (beat_q),
      .wdata (pmem_rdata),
      .wtag  (tag),
      .rline (rline),
      .rtag  (rtag)
   );

   always_comb begin
      state_d      = state_q;
      req_addr_d   = req_addr_q;
      valid_d      = valid_q;
      beat_d       = beat_q;
      fill_flush_d = fill_flush_q;
      unique case (state_q)
         IDLE: begin
            if (imem_read) begin
               req_addr_d = imem_address[31:2];
               state_d    = LOOKUP;
            end
         end
         LOOKUP: begin
            if (hit) begin
               if (imem_read) begin
                  req_addr_d = imem_address[31:2];
               end else begin
                  state_d = IDLE;
               end
            end else begin
               state_d      = FILL;
               fill_flush_d = 1'b0;
            end
         end
         FILL: begin
            // A flush anywhere in the fill must keep this line invalid.
            if (flush) begin
               fill_flush_d = 1'b1;
            end
            if (pmem_resp) begin
               beat_d = beat_q + 1'b1;
               if (beat_q == IMEM_BEAT_BITS'(IMEM_LINE_BEATS - 1)) begin
                  beat_d  = '0;
                  state_d = LOOKUP;
                  if (!flush && !fill_flush_q) begin
                     valid_d[idx] = 1'b1;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (flush) begin
         valid_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         req_addr_q   <= '0;
         valid_q      <= '0;
         beat_q       <= '0;
         fill_flush_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         req_addr_q   <= req_addr_d;
         valid_q      <= valid_d;
         beat_q       <= beat_d;
         fill_flush_q <= fill_flush_d;
      end
   end

   assign imem_resp    = hit;
   assign imem_rdata   = hit ? rline[{req_addr_q[4:2], 5'b0} +: 32] : '0;
   assign pmem_read    = (state_q == FILL);
   assign pmem_address = pmem_read ? {req_addr_q[31:5], 5'b0} : '0;

`ifdef IMEM_CACHE_PERF_EN
   logic [31:0] hit_cnt_q, miss_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         if (hit && (hit_cnt_q != '1)) begin
            hit_cnt_q <= hit_cnt_q + 32'd1;
         end
         if ((state_q == LOOKUP) && !hit && (miss_cnt_q != '1)) begin
            miss_cnt_q <= miss_cnt_q + 32'd1;
         end
      end
   end

   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;
`endif

endmodule
